// File: rtl/painterengine_gpu_pkg.sv
// Shared types and helpers for the GPU pixel writeback path.
//   wb_state_e      : writeback job state (IDLE / RUN / DONE)
//   PIXEL_W         : packed ARGB8888 pixel width
//   BYTES_PER_PIXEL : framebuffer byte step between adjacent pixels
//   argb_pack       : {a,r,g,b} -> 32-bit pixel
//   argb_unpack     : 32-bit pixel -> a,r,g,b channels
package painterengine_gpu_pkg;

  localparam int PIXEL_W         = 32;
  localparam int BYTES_PER_PIXEL = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  function automatic logic [PIXEL_W-1:0] argb_pack(input logic [7:0] a, input logic [7:0] r,
                                                   input logic [7:0] g, input logic [7:0] b);
    return {a, r, g, b};
  endfunction

  function automatic void argb_unpack(input logic [PIXEL_W-1:0] p, output logic [7:0] a,
                                      output logic [7:0] r, output logic [7:0] g,
                                      output logic [7:0] b);
    {a, r, g, b} = p;
  endfunction

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop and occupancy count.
//   clk_i, rst_ni : clock, synchronous active-low reset (flushes pointers/count)
//   push_i/wdata_i: write request and data (ignored when full)
//   pop_i/rdata_o : read request (ignored when empty), head-of-queue data
//   full_o/empty_o/count_o : status, count_o is 0..DEPTH
module painterengine_gpu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // Full is judged on the pre-pop count, so push+pop on a full FIFO is only a pop.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/painterengine_gpu_pixel_writeback.sv
// Buffers blended ARGB pixels and writes them row-major into a framebuffer
// rectangle over an Avalon-MM write master.
//   i_wire_clock/i_wire_resetn : clock, synchronous active-low reset
//   i_wire_start + geometry    : begin a job (base, width, height, byte stride)
//   i_wire_valid, a, r, g, b   : incoming pixel stream (no backpressure)
//   o_wire_busy/o_wire_done    : job running / one-cycle completion pulse
//   o_wire_almost_full         : upstream throttle, o_wire_overflow sticky drop flag
//   o_wire_mem_*               : Avalon write master (write/address/writedata/waitrequest)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pixels and writing them out
// DONE  | one-cycle done pulse, then back to IDLE
module painterengine_gpu_pixel_writeback
  import painterengine_gpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  i_wire_clock,
  input  logic                  i_wire_resetn,
  input  logic                  i_wire_start,
  input  logic [ADDR_WIDTH-1:0] i_wire_base_addr,
  input  logic [15:0]           i_wire_width,
  input  logic [15:0]           i_wire_height,
  input  logic [ADDR_WIDTH-1:0] i_wire_stride,
  input  logic                  i_wire_valid,
  input  logic [7:0]            a,
  input  logic [7:0]            r,
  input  logic [7:0]            g,
  input  logic [7:0]            b,
  output logic                  o_wire_busy,
  output logic                  o_wire_done,
  output logic                  o_wire_almost_full,
  output logic                  o_wire_overflow,
  output logic                  o_wire_mem_write,
  output logic [ADDR_WIDTH-1:0] o_wire_mem_address,
  output logic [31:0]           o_wire_mem_writedata,
  input  logic                  i_wire_mem_waitrequest
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, stride_q, stride_d, addr_q, addr_d;
  logic [15:0]           width_q, width_d, x_q, x_d;
  logic [31:0]           total_q, total_d, accepted_q, accepted_d, written_q, written_d;
  logic                  ovf_q, ovf_d, af_q, af_d, write_q, write_d;
  logic [PIXEL_W-1:0]    wdata_q, wdata_d;

  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count, count_nxt;
  logic [PIXEL_W-1:0]    fifo_rdata;

  logic                  run, accept, room, push, drop, load, x_last;
  logic [15:0]           x_adv, x_cur;
  logic [ADDR_WIDTH-1:0] rb_adv, rb_cur, pix_addr;

  assign run    = (state_q == ST_RUN);
  assign accept = write_q & ~i_wire_mem_waitrequest;
  assign room   = (accepted_q != total_q);
  assign push   = run & i_wire_valid & ~fifo_full & room;
  assign drop   = run & i_wire_valid & fifo_full & room;
  // Load a new pixel when the bus slot is free or is being freed this edge.
  assign load   = run & ~fifo_empty & (~write_q | accept);

  // x/row_base point at the pixel on the bus while write is up, else at the
  // next pixel to write; on an acceptance edge the advanced position is the
  // address of the pixel loaded back-to-back.
  assign x_last   = (x_q == width_q - 16'd1);
  assign x_adv    = x_last ? 16'd0 : x_q + 16'd1;
  assign rb_adv   = x_last ? row_base_q + stride_q : row_base_q;
  assign x_cur    = accept ? x_adv : x_q;
  assign rb_cur   = accept ? rb_adv : row_base_q;
  assign pix_addr = rb_cur + ADDR_WIDTH'(x_cur) * ADDR_WIDTH'(BYTES_PER_PIXEL);

  assign count_nxt = fifo_count + CW'(push) - CW'(load);

  painterengine_gpu_sync_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_wire_clock),
    .rst_ni  (i_wire_resetn),
    .push_i  (push),
    .wdata_i (argb_pack(a, r, g, b)),
    .pop_i   (load),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    addr_d     = addr_q;
    width_d    = width_q;
    x_d        = x_q;
    total_d    = total_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    ovf_d      = ovf_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    af_d       = (count_nxt >= CW'(AFULL_LEVEL));

    if (push) accepted_d = accepted_q + 32'd1;
    if (drop) ovf_d = 1'b1;
    if (accept) begin
      written_d  = written_q + 32'd1;
      x_d        = x_adv;
      row_base_d = rb_adv;
    end
    if (load) begin
      write_d = 1'b1;
      addr_d  = pix_addr;
      wdata_d = fifo_rdata;
    end else if (accept) begin
      write_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_wire_start) begin
          row_base_d = i_wire_base_addr;
          stride_d   = i_wire_stride;
          width_d    = i_wire_width;
          total_d    = 32'(i_wire_width) * 32'(i_wire_height);
          x_d        = 16'd0;
          accepted_d = 32'd0;
          written_d  = 32'd0;
          ovf_d      = 1'b0;
          state_d    = (i_wire_width != 16'd0 && i_wire_height != 16'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN:  if (written_q == total_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      state_q    <= ST_IDLE;
      row_base_q <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
      width_q    <= '0;
      x_q        <= '0;
      total_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      ovf_q      <= 1'b0;
      af_q       <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      addr_q     <= addr_d;
      width_q    <= width_d;
      x_q        <= x_d;
      total_q    <= total_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
      ovf_q      <= ovf_d;
      af_q       <= af_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
    end
  end

  assign o_wire_busy          = run;
  assign o_wire_done          = (state_q == ST_DONE);
  assign o_wire_almost_full   = af_q;
  assign o_wire_overflow      = ovf_q;
  assign o_wire_mem_write     = write_q;
  assign o_wire_mem_address   = addr_q;
  assign o_wire_mem_writedata = wdata_q;

endmodule
